seq_divider: RTL



---
 rtl/seq_divider.sv | 110 +++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// Produces one quotient bit per clock using trial subtraction and a
// start/done handshake. A zero divisor short-circuits to a saturated result.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH:0]   r_q;      // partial remainder, one guard bit
    logic [WIDTH-1:0] q_q;      // holds the dividend, shifts out as quotient shifts in
    logic [WIDTH-1:0] d_q;      // latched divisor
    logic [CW-1:0]    cnt;      // completed iterations
    logic             dz_pend;  // zero divisor: result is published one cycle after entry to DONE

    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] sum;
    logic             borrow;
    logic [WIDTH:0]   r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             last_iter;

    // One iteration: shift in the next dividend bit, then trial-subtract via
    // ones'-complement add with carry-in; a missing carry-out means borrow.
    always_comb begin
        r_sh      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        sum       = {1'b0, r_sh} + {1'b0, ~{1'b0, d_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
        borrow    = ~sum[WIDTH+1];
        r_nxt     = borrow ? r_sh : sum[WIDTH:0];
        q_nxt     = {q_q[WIDTH-2:0], ~borrow};
        last_iter = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt         <= '0;
            dz_pend     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d_q <= divisor;
                        q_q <= dividend;
                        r_q <= '0;
                        cnt <= '0;
                        if (divisor != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state   <= DONE;
                            dz_pend <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_q <= r_nxt;
                    q_q <= q_nxt;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_nxt;
                        remainder   <= r_nxt[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (dz_pend) begin
                        // q_q still holds the untouched dividend
                        dz_pend     <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= '1;
                        remainder   <= q_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
